// File: rtl/viterbi_pkg.sv
// ---------------------------------------------------------------------------
// viterbi_pkg
//   Shared types and helpers for the rate-1/2 Viterbi decoder datapath.
//   SOFT_W_DEF / MET_W_DEF : default soft-symbol and branch-metric widths
//   bm_t / bm_vec_t        : one branch metric / the four metrics of a beat
//   met_wide_t             : wide carrier so min4() serves any metric width
//   min4()                 : smallest of four values (BMC and ACS normaliser)
// ---------------------------------------------------------------------------
package viterbi_pkg;

    localparam int SOFT_W_DEF = 3;
    localparam int MET_W_DEF  = SOFT_W_DEF + 1;
    localparam int MIN4_W     = 16;

    typedef logic [MET_W_DEF-1:0] bm_t;
    typedef bm_t                  bm_vec_t [4];
    typedef logic [MIN4_W-1:0]    met_wide_t;

    function automatic met_wide_t min4(input met_wide_t a, input met_wide_t b,
                                       input met_wide_t c, input met_wide_t d);
        met_wide_t ab;
        met_wide_t cd;
        ab = (a < b) ? a : b;
        cd = (c < d) ? c : d;
        return (ab < cd) ? ab : cd;
    endfunction

endpackage

// File: rtl/bmc_sym_dist.sv
// ---------------------------------------------------------------------------
// bmc_sym_dist
//   Combinational distance of one received symbol to an expected '0' and '1'.
//   sym       in  SOFT_W  offset-binary soft symbol (0 = strong '0')
//   mode_hard in  1       use only the symbol MSB as a 0/1 decision
//   erase     in  1       punctured position: both distances forced to 0
//   d0, d1    out SOFT_W  distance to expected bit 0 / bit 1
// ---------------------------------------------------------------------------
module bmc_sym_dist #(
    parameter int SOFT_W = 3
) (
    input  logic [SOFT_W-1:0] sym,
    input  logic              mode_hard,
    input  logic              erase,
    output logic [SOFT_W-1:0] d0,
    output logic [SOFT_W-1:0] d1
);

    localparam logic [SOFT_W-1:0] SOFT_MAX = '1;

    always_comb begin
        d0 = '0;
        d1 = '0;
        if (!erase) begin
            if (mode_hard) begin
                d0[0] = sym[SOFT_W-1];
                d1[0] = !sym[SOFT_W-1];
            end else begin
                d0 = sym;
                d1 = SOFT_MAX - sym;
            end
        end
    end

endmodule

// File: rtl/bmc_soft_pipe.sv
// ---------------------------------------------------------------------------
// bmc_soft_pipe
//   Two-stage branch-metric unit feeding the ACS array. Stage 1 registers
//   per-symbol distances, stage 2 registers the four min-normalised metrics.
//   clk, rst            clock / synchronous active-high reset
//   mode_hard           hard (MSB) or soft decisions, travels with the beat
//   in_valid/in_ready   input handshake; in_ready = pipe can advance
//   rx_sym, rx_erase    received symbol pair and per-symbol erasure
//   in_last             last beat of frame
//   out_valid/out_ready output handshake towards the ACS
//   bm[k]               metric for expected pair k (k[1] <-> rx_sym[1])
//   out_last            in_last delayed with its beat
//   sym_cnt             index of the presented beat within its frame
// ---------------------------------------------------------------------------
module bmc_soft_pipe
    import viterbi_pkg::*;
#(
    parameter int SOFT_W = SOFT_W_DEF,
    parameter int MET_W  = SOFT_W + 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode_hard,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0][SOFT_W-1:0]  rx_sym,
    input  logic [1:0]              rx_erase,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0][MET_W-1:0]   bm,
    output logic                    out_last,
    output logic [CNT_W-1:0]        sym_cnt
);

    localparam int RAW_W = SOFT_W + 1;

    if (MET_W < SOFT_W + 1) begin : g_bad_met_w
        $error("bmc_soft_pipe: MET_W must be at least SOFT_W+1");
    end
    if (RAW_W > MIN4_W) begin : g_bad_soft_w
        $error("bmc_soft_pipe: SOFT_W too wide for min4 carrier");
    end

    // The whole pipe moves as one; a stalled output freezes stage 1 too.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [1:0][SOFT_W-1:0] d0_c, d1_c;
    logic [1:0][SOFT_W-1:0] d0_q, d1_q;
    logic                   s1_valid;
    logic                   s1_last;

    for (genvar i = 0; i < 2; i++) begin : g_dist
        bmc_sym_dist #(.SOFT_W(SOFT_W)) u_dist (
            .sym       (rx_sym[i]),
            .mode_hard (mode_hard),
            .erase     (rx_erase[i]),
            .d0        (d0_c[i]),
            .d1        (d1_c[i])
        );
    end

    logic [3:0][RAW_W-1:0] raw;
    logic [RAW_W-1:0]      raw_min;
    logic [3:0][MET_W-1:0] bm_c;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            raw[k] = RAW_W'(k[1] ? d1_q[1] : d0_q[1])
                   + RAW_W'(k[0] ? d1_q[0] : d0_q[0]);
        end
        raw_min = RAW_W'(min4(met_wide_t'(raw[0]), met_wide_t'(raw[1]),
                              met_wide_t'(raw[2]), met_wide_t'(raw[3])));
        for (int k = 0; k < 4; k++) begin
            bm_c[k] = MET_W'(raw[k] - raw_min);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            d0_q      <= '0;
            d1_q      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            bm        <= '0;
            sym_cnt   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                sym_cnt <= out_last ? '0 : sym_cnt + 1'b1;
            end
            if (adv) begin
                s1_valid  <= in_valid;
                out_valid <= s1_valid;
                if (in_valid) begin
                    d0_q    <= d0_c;
                    d1_q    <= d1_c;
                    s1_last <= in_last;
                end
                if (s1_valid) begin
                    bm       <= bm_c;
                    out_last <= s1_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_bmc_soft_pipe.sv
module tb_bmc_soft_pipe;

    localparam int SOFT_W = 3;
    localparam int MET_W  = 4;
    localparam int CNT_W  = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   mode_hard = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [1:0][SOFT_W-1:0] rx_sym = '0;
    logic [1:0]             rx_erase = '0;
    logic                   in_last = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [3:0][MET_W-1:0]  bm;
    logic                   out_last;
    logic [CNT_W-1:0]       sym_cnt;

    bmc_soft_pipe #(.SOFT_W(SOFT_W), .MET_W(MET_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_hard (mode_hard),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rx_sym    (rx_sym),
        .rx_erase  (rx_erase),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bm        (bm),
        .out_last  (out_last),
        .sym_cnt   (sym_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SOFT_W-1:0]     r1;
        logic [SOFT_W-1:0]     r0;
        logic                  hard;
        logic [1:0]            er;
        logic                  last;
        logic [3:0][MET_W-1:0] ebm;
    } stim_t;

    typedef struct {
        logic [3:0][MET_W-1:0] ebm;
        logic                  last;
        logic [CNT_W-1:0]      cnt;
        int                    acc_cyc;
    } exp_t;

    stim_t            stim[$];
    exp_t             sb[$];
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_idx  = '0;

    // Reference: metric of pair k = sum of per-symbol distances, minus the minimum.
    function automatic logic [3:0][MET_W-1:0] model_bm(input logic [SOFT_W-1:0] r1,
            input logic [SOFT_W-1:0] r0, input logic hard, input logic [1:0] er);
        int d [2][2];
        int raw [4];
        int m;
        logic [SOFT_W-1:0] r;
        logic [3:0][MET_W-1:0] res;
        for (int i = 0; i < 2; i++) begin
            r = (i == 1) ? r1 : r0;
            for (int b = 0; b < 2; b++) begin
                if (er[i])     d[i][b] = 0;
                else if (hard) d[i][b] = (int'(r[SOFT_W-1]) != b) ? 1 : 0;
                else           d[i][b] = (b == 1) ? (7 - int'(r)) : int'(r);
            end
        end
        m = 1000;
        for (int k = 0; k < 4; k++) begin
            raw[k] = d[1][k / 2] + d[0][k % 2];
            if (raw[k] < m) m = raw[k];
        end
        for (int k = 0; k < 4; k++) res[k] = MET_W'(raw[k] - m);
        return res;
    endfunction

    task automatic add_stim(input logic [SOFT_W-1:0] r1, input logic [SOFT_W-1:0] r0,
            input logic hard, input logic [1:0] er, input logic last,
            input logic [3:0][MET_W-1:0] ebm);
        stim_t s;
        s.r1 = r1; s.r0 = r0; s.hard = hard; s.er = er; s.last = last; s.ebm = ebm;
        stim.push_back(s);
    endtask

    // Streams the queued stimulus; expectations go to sb on accept, compared on output handshake.
    task automatic run_beats(input string name, input bit stall_mode);
        int                    cyc = 0;
        bit                    stalled = 0;
        logic [3:0][MET_W-1:0] snap_bm = '0;
        logic                  snap_last = 1'b0;
        logic [CNT_W-1:0]      snap_cnt = '0;
        exp_t                  e;
        while ((stim.size() > 0 || sb.size() > 0) && cyc < 300) begin
            @(negedge clk);
            out_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
            if (stim.size() > 0) begin
                in_valid  = 1'b1;
                rx_sym[1] = stim[0].r1;
                rx_sym[0] = stim[0].r0;
                mode_hard = stim[0].hard;
                rx_erase  = stim[0].er;
                in_last   = stim[0].last;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || bm !== snap_bm || out_last !== snap_last
                        || sym_cnt !== snap_cnt) begin
                    failures++;
                    $display("FAIL %s stall_hold: got valid=%b bm=%h last=%b cnt=%0d, need valid=1 bm=%h last=%b cnt=%0d",
                             name, out_valid, bm, out_last, sym_cnt, snap_bm, snap_last, snap_cnt);
                end
            end
            stalled = 0;
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s in_ready_stall: got %b need 0", name, in_ready);
                end
                stalled   = 1;
                snap_bm   = bm;
                snap_last = out_last;
                snap_cnt  = sym_cnt;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_beat: got bm=%h with nothing expected", name, bm);
                end else begin
                    e = sb.pop_front();
                    if (bm !== e.ebm || out_last !== e.last || sym_cnt !== e.cnt) begin
                        failures++;
                        $display("FAIL %s beat: got bm=%h last=%b cnt=%0d, need bm=%h last=%b cnt=%0d",
                                 name, bm, out_last, sym_cnt, e.ebm, e.last, e.cnt);
                    end
                    if (!stall_mode) begin
                        checks++;
                        if (cyc - e.acc_cyc != 2) begin
                            failures++;
                            $display("FAIL %s latency: got %0d need 2", name, cyc - e.acc_cyc);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.ebm = stim[0].ebm; e.last = stim[0].last; e.cnt = exp_idx; e.acc_cyc = cyc;
                sb.push_back(e);
                exp_idx = stim[0].last ? '0 : exp_idx + 1'b1;
                stim.delete(0);
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (stim.size() > 0 || sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got %0d unsent, %0d outstanding, need 0", name, stim.size(), sb.size());
            stim.delete();
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || bm !== '0 || out_last !== 1'b0 || sym_cnt !== '0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b rdy=%b bm=%h last=%b cnt=%0d, need 0 1 0 0 0",
                     out_valid, in_ready, bm, out_last, sym_cnt);
        end
        rst = 1'b0;
        exp_idx = '0;
    endtask

    task automatic test_directed();
        add_stim(3'd5, 3'd3, 1'b0, 2'b00, 1'b0, {4'd1, 4'd0, 4'd4, 4'd3});
        add_stim(3'd5, 3'd3, 1'b1, 2'b00, 1'b0, {4'd1, 4'd0, 4'd2, 4'd1});
        add_stim(3'd7, 3'd0, 1'b0, 2'b00, 1'b0, {4'd7, 4'd0, 4'd14, 4'd7});
        add_stim(3'd7, 3'd5, 1'b0, 2'b01, 1'b0, {4'd0, 4'd0, 4'd7, 4'd7});
        add_stim(3'd7, 3'd5, 1'b0, 2'b11, 1'b1, {4'd0, 4'd0, 4'd0, 4'd0});
        run_beats("directed", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [SOFT_W-1:0] a, b;
        logic              h;
        logic [1:0]        er;
        for (int n = 0; n < 8; n++) begin
            a  = SOFT_W'($urandom_range(0, 7));
            b  = SOFT_W'($urandom_range(0, 7));
            h  = 1'($urandom_range(0, 1));
            er = 2'($urandom_range(0, 3));
            add_stim(a, b, h, er, n == 7, model_bm(a, b, h, er));
        end
        run_beats("back_to_back", 1'b1);
    endtask

    task automatic test_frame();
        logic [SOFT_W-1:0] a, b;
        for (int n = 0; n < 8; n++) begin
            a = SOFT_W'(n);
            b = SOFT_W'(7 - n);
            add_stim(a, b, 1'b0, 2'b00, (n == 4) || (n == 7), model_bm(a, b, 1'b0, 2'b00));
        end
        run_beats("frame", 1'b0);
    endtask

    task automatic test_reset_midframe();
        logic [3:0][MET_W-1:0] exp_d;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            rx_sym[1] = SOFT_W'(n + 1);
            rx_sym[0] = SOFT_W'(2);
            mode_hard = 1'b0;
            rx_erase  = 2'b00;
            in_last   = 1'b0;
        end
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sym_cnt !== '0 || bm !== '0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_state: got valid=%b cnt=%0d bm=%h last=%b rdy=%b, need 0 0 0 0 1",
                     out_valid, sym_cnt, bm, out_last, in_ready);
        end
        in_valid  = 1'b1;
        rx_sym[1] = 3'd6;
        rx_sym[0] = 3'd1;
        mode_hard = 1'b0;
        rx_erase  = 2'b00;
        in_last   = 1'b1;
        exp_d     = model_bm(3'd6, 3'd1, 1'b0, 2'b00);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_flush: got out_valid=%b need 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || bm !== exp_d || sym_cnt !== '0 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_beat: got valid=%b bm=%h cnt=%0d last=%b, need 1 %h 0 1",
                     out_valid, bm, sym_cnt, out_last, exp_d);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || sym_cnt !== '0) begin
            failures++;
            $display("FAIL rst_mid_after: got valid=%b cnt=%0d, need 0 0", out_valid, sym_cnt);
        end
        exp_idx = '0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_frame();
        test_reset_midframe();
        test_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
